// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the operand stage: data width, the opcode
// encodings the stage understands, the stage FSM encoding and an
// immediate sign-extension helper.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } opstage_state_t;

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32 x XLEN integer register file.
//   clk, rst             : clock, synchronous active-high clear of all registers
//   rs1_addr_i/rs1_data_o: combinational read port 1
//   rs2_addr_i/rs2_data_o: combinational read port 2
//   dbg_addr_i/dbg_data_o: combinational debug read port
//   we_i, wr_addr_i,
//   wr_data_i            : synchronous write port; writes to x0 are dropped
module reg_file
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [4:0]      dbg_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] dbg_data_o,
  input  logic            we_i,
  input  logic [4:0]      wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i
);

  logic [XLEN-1:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (wr_addr_i != 5'd0)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  // x0 is forced to zero on read as well, so it never depends on storage.
  assign rs1_data_o = (rs1_addr_i == 5'd0) ? '0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? '0 : regs_q[rs2_addr_i];
  assign dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/operand_stage.sv
// Decode/operand stage of the multi-cycle RV32I core, feeding the ALU.
// Accepts one instruction over instr_valid/instr_ready, reads its sources,
// drives registered ALU operands, waits ALU_WAIT cycles, then writes the
// ALU result back to rd.
//   clk, rst                 : clock, synchronous active-high reset
//   instr_valid/instr_ready  : fetch handshake (ready only in IDLE)
//   instr, instr_pc          : instruction word and its address
//   opcode/func3/func7/op1/op2 : registered ALU controls and operands
//   alu_result               : ALU output, sampled in WB
//   done, illegal            : retire pulse, and unsupported-opcode flag
//   dbg_addr, dbg_data       : combinational debug register read
module operand_stage
  import rv32i_pkg::*;
#(
  parameter int ALU_WAIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic [31:0]     instr_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic            func7,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  input  logic [XLEN-1:0] alu_result,
  output logic            done,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int CW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_WAIT - 1);

  opstage_state_t  state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     pcr_q, pcr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      func3_q, func3_d;
  logic            func7_q, func7_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;

  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            rf_we;

  reg_file u_reg_file (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr_i (ir_q[19:15]),
    .rs2_addr_i (ir_q[24:20]),
    .dbg_addr_i (dbg_addr),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .dbg_data_o (dbg_data),
    .we_i       (rf_we),
    .wr_addr_i  (ir_q[11:7]),
    .wr_data_i  (alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;
      pcr_q    <= '0;
      cnt_q    <= '0;
      opcode_q <= '0;
      func3_q  <= '0;
      func7_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pcr_q    <= pcr_d;
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
      func3_q  <= func3_d;
      func7_q  <= func7_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pcr_d    = pcr_q;
    cnt_d    = cnt_q;
    opcode_d = opcode_q;
    func3_d  = func3_q;
    func7_d  = func7_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    rf_we    = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          pcr_d   = instr_pc;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        state_d = ST_EXEC;
        cnt_d   = CNT_LOAD;
        case (ir_q[6:0])
          OPC_OP: begin
            opcode_d = OPC_OP;
            func3_d  = ir_q[14:12];
            func7_d  = ir_q[30];
            op1_d    = rs1_data;
            op2_d    = rs2_data;
          end
          OPC_OP_IMM: begin
            opcode_d = OPC_OP_IMM;
            func3_d  = ir_q[14:12];
            // Only shifts carry an arithmetic/logical select in bit 30;
            // for every other OP-IMM it is just an immediate bit.
            func7_d  = (ir_q[14:12] == 3'b101) ? ir_q[30] : 1'b0;
            op1_d    = rs1_data;
            op2_d    = sext12(ir_q[31:20]);
          end
          OPC_LUI, OPC_AUIPC: begin
            // Both become an ADDI of the upper immediate onto 0 or the PC.
            opcode_d = OPC_OP_IMM;
            func3_d  = 3'b000;
            func7_d  = 1'b0;
            op1_d    = (ir_q[6:0] == OPC_AUIPC) ? pcr_q : '0;
            op2_d    = {ir_q[31:12], 12'h000};
          end
          default: begin
            illegal = 1'b1;
            done    = 1'b1;
            cnt_d   = cnt_q;
            state_d = ST_IDLE;
          end
        endcase
      end

      ST_EXEC: begin
        if (cnt_q == '0) state_d = ST_WB;
        else             cnt_d   = cnt_q - 1'b1;
      end

      ST_WB: begin
        rf_we   = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign opcode      = opcode_q;
  assign func3       = func3_q;
  assign func7       = func7_q;
  assign op1         = op1_q;
  assign op2         = op2_q;

endmodule

// File: tb/tb_operand_stage.sv
module tb_operand_stage;

  typedef struct {
    logic        ill;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] res;
    logic        ill;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  chk_reg;
    logic [31:0] chk_val;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        instr_valid[2];
  logic        instr_ready[2];
  logic [31:0] instr      [2];
  logic [31:0] instr_pc   [2];
  logic [6:0]  opcode     [2];
  logic [2:0]  func3      [2];
  logic        func7      [2];
  logic [31:0] op1        [2];
  logic [31:0] op2        [2];
  logic [31:0] alu_result [2];
  logic        done       [2];
  logic        illegal    [2];
  logic [4:0]  dbg_addr   [2];
  logic [31:0] dbg_data   [2];

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  exp_t q0[$];
  exp_t q1[$];
  vec_t vecs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  operand_stage #(.ALU_WAIT(1)) dut0 (
    .clk(clk), .rst(rst[0]), .instr_valid(instr_valid[0]), .instr_ready(instr_ready[0]),
    .instr(instr[0]), .instr_pc(instr_pc[0]), .opcode(opcode[0]), .func3(func3[0]),
    .func7(func7[0]), .op1(op1[0]), .op2(op2[0]), .alu_result(alu_result[0]),
    .done(done[0]), .illegal(illegal[0]), .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0])
  );

  operand_stage #(.ALU_WAIT(3)) dut1 (
    .clk(clk), .rst(rst[1]), .instr_valid(instr_valid[1]), .instr_ready(instr_ready[1]),
    .instr(instr[1]), .instr_pc(instr_pc[1]), .opcode(opcode[1]), .func3(func3[1]),
    .func7(func7[1]), .op1(op1[1]), .op2(op2[1]), .alu_result(alu_result[1]),
    .done(done[1]), .illegal(illegal[1]), .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops one expectation per done pulse.
  task automatic mon(input int d);
    exp_t e;
    int   w;
    w = (d == 0) ? 1 : 3;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      nvec++; nerr++;
      $display("FAIL unexpected_done dut%0d: got done=1, expected no retire", d);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("illegal%0d", d), {31'b0, illegal[d]}, {31'b0, e.ill});
    chk($sformatf("latency%0d", d), cyc - e.acc, e.ill ? 0 : 1 + w);
    chk($sformatf("opcode%0d", d), {25'b0, opcode[d]}, {25'b0, e.opc});
    chk($sformatf("func3_%0d", d), {29'b0, func3[d]}, {29'b0, e.f3});
    chk($sformatf("func7_%0d", d), {31'b0, func7[d]}, {31'b0, e.f7});
    chk($sformatf("op1_%0d", d), op1[d], e.a);
    chk($sformatf("op2_%0d", d), op2[d], e.b);
  endtask

  always @(negedge clk) begin
    if (done[0]) mon(0);
    if (done[1]) mon(1);
  end

  task automatic do_reset(input int d);
    @(negedge clk);
    rst[d] = 1'b1;
    repeat (2) @(negedge clk);
    rst[d] = 1'b0;
    dbg_addr[d] = 5'd5;
    @(negedge clk);
    chk($sformatf("rst_ready%0d", d), {31'b0, instr_ready[d]}, 32'd1);
    chk($sformatf("rst_done%0d", d), {31'b0, done[d]}, 32'd0);
    chk($sformatf("rst_op1_%0d", d), op1[d], 32'd0);
    chk($sformatf("rst_op2_%0d", d), op2[d], 32'd0);
    chk($sformatf("rst_x5_%0d", d), dbg_data[d], 32'd0);
  endtask

  task automatic run_one(input int d, input vec_t v);
    exp_t e;
    int   n;
    @(negedge clk);
    chk($sformatf("ready_before%0d", d), {31'b0, instr_ready[d]}, 32'd1);
    instr[d]       = v.instr;
    instr_pc[d]    = v.pc;
    alu_result[d]  = v.res;
    instr_valid[d] = 1'b1;
    e.ill = v.ill; e.opc = v.opc; e.f3 = v.f3; e.f7 = v.f7;
    e.a = v.a; e.b = v.b; e.acc = cyc + 1;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk);
    #1 instr_valid[d] = 1'b0;
    @(negedge clk);
    n = 0;
    while (!instr_ready[d] && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      nvec++; nerr++;
      $display("FAIL timeout dut%0d: instr_ready stayed 0, expected 1 within 30 cycles", d);
    end
    dbg_addr[d] = v.chk_reg;
    #1 chk($sformatf("reg_x%0d_dut%0d", v.chk_reg, d), dbg_data[d], v.chk_val);
  endtask

  task automatic abort_case(input int d);
    @(negedge clk);
    instr[d] = 32'h00700313;  // ADDI x6,x0,7
    instr_pc[d] = 32'h0;
    alu_result[d] = 32'd7;
    instr_valid[d] = 1'b1;
    @(posedge clk);
    #1 instr_valid[d] = 1'b0;
    @(negedge clk);           // DECODE
    @(negedge clk);           // first EXEC cycle
    rst[d] = 1'b1;
    @(posedge clk);
    #1 rst[d] = 1'b0;
    @(negedge clk);
    chk($sformatf("abort_ready%0d", d), {31'b0, instr_ready[d]}, 32'd1);
    chk($sformatf("abort_done%0d", d), {31'b0, done[d]}, 32'd0);
    chk($sformatf("abort_op2_%0d", d), op2[d], 32'd0);
    dbg_addr[d] = 5'd6;
    #1 chk($sformatf("abort_x6_%0d", d), dbg_data[d], 32'd0);
    dbg_addr[d] = 5'd1;
    #1 chk($sformatf("abort_x1_%0d", d), dbg_data[d], 32'd0);
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] r,
                              input logic il, input logic [6:0] o, input logic [2:0] f3,
                              input logic f7, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] cr, input logic [31:0] cv);
    vec_t v;
    v.instr = i; v.pc = pc; v.res = r; v.ill = il; v.opc = o; v.f3 = f3; v.f7 = f7;
    v.a = a; v.b = b; v.chk_reg = cr; v.chk_val = cv;
    return v;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; instr_valid[d] = 1'b0; instr[d] = '0; instr_pc[d] = '0;
      alu_result[d] = '0; dbg_addr[d] = '0;
    end
    // LUI x1,0x00123
    vecs.push_back(mk(32'h001230B7, 32'h100, 32'h00123000, 0, 7'b0010011, 3'd0, 0,
                      32'h0, 32'h00123000, 5'd1, 32'h00123000));
    // ADDI x2,x1,0x456
    vecs.push_back(mk(32'h45608113, 32'h104, 32'h00123456, 0, 7'b0010011, 3'd0, 0,
                      32'h00123000, 32'h00000456, 5'd2, 32'h00123456));
    // SUB x3,x2,x1
    vecs.push_back(mk(32'h401101B3, 32'h108, 32'h00000456, 0, 7'b0110011, 3'd0, 1,
                      32'h00123456, 32'h00123000, 5'd3, 32'h00000456));
    // ADDI x4,x0,-1024
    vecs.push_back(mk(32'hC0000213, 32'h10C, 32'hFFFFFC00, 0, 7'b0010011, 3'd0, 0,
                      32'h0, 32'hFFFFFC00, 5'd4, 32'hFFFFFC00));
    // ADDI x0,x0,5 : x0 must stay 0
    vecs.push_back(mk(32'h00500013, 32'h110, 32'h00000005, 0, 7'b0010011, 3'd0, 0,
                      32'h0, 32'h00000005, 5'd0, 32'h0));
    // JAL : illegal, ALU outputs hold, x4 untouched
    vecs.push_back(mk(32'h0000006F, 32'h114, 32'hDEADBEEF, 1, 7'b0010011, 3'd0, 0,
                      32'h0, 32'h00000005, 5'd4, 32'hFFFFFC00));
    // AUIPC x7,0x1 at pc 0x200
    vecs.push_back(mk(32'h00001397, 32'h200, 32'h00001200, 0, 7'b0010011, 3'd0, 0,
                      32'h200, 32'h00001000, 5'd7, 32'h00001200));
    // SRAI x8,x4,4 : func7 carried for shifts
    vecs.push_back(mk(32'h40425413, 32'h204, 32'hFFFFFFC0, 0, 7'b0010011, 3'd5, 1,
                      32'hFFFFFC00, 32'h00000404, 5'd8, 32'hFFFFFFC0));
    // ADDI x9,x0,0x400 : bit 30 set but func7 must be 0
    vecs.push_back(mk(32'h40000493, 32'h208, 32'h00000400, 0, 7'b0010011, 3'd0, 0,
                      32'h0, 32'h00000400, 5'd9, 32'h00000400));

    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      foreach (vecs[k]) run_one(d, vecs[k]);
      abort_case(d);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty0", q0.size(), 32'd0);
    chk("sb_empty1", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
